// File: rtl/spi_master.sv
// SPI mode-0 master: MSB first, one DATA_W-bit word per chip-select frame.
// sclk is a registered divide of clk; everything lives in the clk domain.
module spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              data_valid,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned GAP_W = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e              state_q,      state_d;
  logic [DIV_W-1:0]    div_cnt_q,    div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q,    bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q,    gap_cnt_d;
  logic [DATA_W-1:0]   tx_shift_q,   tx_shift_d;
  logic [DATA_W-1:0]   rx_shift_q,   rx_shift_d;
  logic [DATA_W-1:0]   rx_data_q,    rx_data_d;
  logic                data_valid_q, data_valid_d;
  logic                sclk_q,       sclk_d;
  logic                cs_q,         cs_d;
  logic                mosi_q,       mosi_d;
  logic                busy_q,       busy_d;
  logic                div_done;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      data_valid_q <= 1'b0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      data_valid_q <= data_valid_d;
      sclk_q       <= sclk_d;
      cs_q         <= cs_d;
      mosi_q       <= mosi_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and output logic; every phase lasts CLK_DIV cycles
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    data_valid_d = 1'b0;
    sclk_d       = sclk_q;
    cs_d         = cs_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    div_done     = (div_cnt_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          tx_shift_d = tx_data;
          mosi_d     = tx_data[DATA_W-1];
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        if (div_done) begin
          // First rising sclk edge: slave has held the MSB on miso since cs fell
          div_cnt_d  = '0;
          sclk_d     = 1'b1;
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
          state_d    = HIGH;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      HIGH: begin
        if (div_done) begin
          div_cnt_d = '0;
          sclk_d    = 1'b0;
          state_d   = LOW;
          // After the last bit mosi keeps the LSB through the closing low phase
          if (bit_cnt_q != BIT_LAST) begin
            tx_shift_d = tx_shift_q << 1;
            mosi_d     = tx_shift_q[DATA_W-2];
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      LOW: begin
        if (div_done) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            cs_d         = 1'b1;
            data_valid_d = 1'b1;
            rx_data_d    = rx_shift_q;
            gap_cnt_d    = '0;
            if (CS_GAP == 0) begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = GAP;
            end
          end else begin
            sclk_d     = 1'b1;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
            state_d    = HIGH;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = busy_q;
  assign rx_data    = rx_data_q;
  assign data_valid = data_valid_q;
  assign sclk       = sclk_q;
  assign cs         = cs_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2/CS_GAP=4 and CLK_DIV=1/CS_GAP=0),
// a frame-level bus monitor, a behavioural slave and a table + random stimulus.
module tb_spi_master;

  localparam int unsigned DW    = 8;
  localparam int unsigned A_DIV = 2;
  localparam int unsigned A_GAP = 4;
  localparam int unsigned B_DIV = 1;
  localparam int unsigned B_GAP = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data [2];
  logic          tx_start [2];
  logic          busy [2];
  logic [DW-1:0] rx_data [2];
  logic          dv [2];
  logic          sclk [2];
  logic          cs [2];
  logic          mosi [2];
  logic          miso [2];

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(A_DIV), .DATA_W(DW), .CS_GAP(A_GAP)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_start(tx_start[0]),
    .busy(busy[0]), .rx_data(rx_data[0]), .data_valid(dv[0]), .sclk(sclk[0]),
    .cs(cs[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master #(.CLK_DIV(B_DIV), .DATA_W(DW), .CS_GAP(B_GAP)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_start(tx_start[1]),
    .busy(busy[1]), .rx_data(rx_data[1]), .data_valid(dv[1]), .sclk(sclk[1]),
    .cs(cs[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? int'(A_DIV) : int'(B_DIV);
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? int'(A_GAP) : int'(B_GAP);
  endfunction

  int checks   = 0;
  int failures = 0;

  // slave model / loopback selection
  bit            loop_en [2];
  logic [DW-1:0] slave_pat [2];
  logic          slave_bit [2];
  int            slave_k [2];

  assign miso[0] = loop_en[0] ? mosi[0] : slave_bit[0];
  assign miso[1] = loop_en[1] ? mosi[1] : slave_bit[1];

  // monitor statistics
  bit            mon_en = 1'b0;
  bit            p_cs [2]   = '{1'b1, 1'b1};
  bit            p_sclk [2] = '{1'b0, 1'b0};
  bit            p_busy [2] = '{1'b0, 1'b0};
  int            cs_lo_len [2], cs_hi_len [2], last_lo_len [2], last_gap [2];
  int            cur_rise [2], last_rise [2], hi_len [2], hi_min [2], hi_max [2];
  int            busy_len [2], last_busy_len [2], dv_cnt [2], frames [2];
  int            bad_sclk [2], bad_dv [2];
  logic [DW-1:0] mosi_word [2], last_mosi [2], rx_last [2], rx_prev [2];

  // Bus monitor and slave: observes both links every falling clk edge
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (mon_en) begin
          if (!cs[i] && p_cs[i]) begin
            last_gap[i]  = cs_hi_len[i];
            cs_lo_len[i] = 1;
            cur_rise[i]  = 0;
            mosi_word[i] = '0;
            hi_min[i]    = 1000;
            hi_max[i]    = 0;
            if (sclk[i] || p_sclk[i]) bad_sclk[i]++;
          end else if (!cs[i]) begin
            cs_lo_len[i]++;
          end
          if (cs[i] && !p_cs[i]) begin
            last_lo_len[i] = cs_lo_len[i];
            last_rise[i]   = cur_rise[i];
            last_mosi[i]   = mosi_word[i];
            cs_hi_len[i]   = 1;
            frames[i]++;
            if (sclk[i] || p_sclk[i]) bad_sclk[i]++;
          end else if (cs[i]) begin
            cs_hi_len[i]++;
          end
          if (cs[i] && sclk[i]) bad_sclk[i]++;

          if (sclk[i] && !p_sclk[i]) begin
            cur_rise[i]++;
            mosi_word[i] = {mosi_word[i][DW-2:0], mosi[i]};
            hi_len[i]    = 1;
          end else if (sclk[i] && p_sclk[i]) begin
            hi_len[i]++;
          end else if (!sclk[i] && p_sclk[i]) begin
            if (hi_len[i] < hi_min[i]) hi_min[i] = hi_len[i];
            if (hi_len[i] > hi_max[i]) hi_max[i] = hi_len[i];
            slave_k[i]++;
            if (slave_k[i] < DW) slave_bit[i] = slave_pat[i][DW-1-slave_k[i]];
          end
          if (cs[i]) begin
            slave_k[i]   = 0;
            slave_bit[i] = slave_pat[i][DW-1];
          end

          if (busy[i] && !p_busy[i]) busy_len[i] = 1;
          else if (busy[i]) busy_len[i]++;
          else if (p_busy[i]) last_busy_len[i] = busy_len[i];

          if (dv[i]) begin
            dv_cnt[i]++;
            rx_prev[i] = rx_last[i];
            rx_last[i] = rx_data[i];
            if (!(cs[i] && !p_cs[i])) bad_dv[i]++;
          end
        end
        p_cs[i]   = cs[i];
        p_sclk[i] = sclk[i];
        p_busy[i] = busy[i];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_flags(input int i);
    bad_sclk[i] = 0;
    bad_dv[i]   = 0;
  endtask

  task automatic wait_busy(input int i, input logic v, input string tag);
    int n = 0;
    while (busy[i] !== v && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("%s.wait_busy%0d", tag, v), 32'(busy[i]), 32'(v));
  endtask

  // Single-cycle request; checks the first-cycle response, then scrambles tx_data
  task automatic start_frame(input int i, input logic [DW-1:0] w, input string tag);
    tx_data[i]  = w;
    tx_start[i] = 1'b1;
    @(negedge clk);
    #1;
    tx_start[i] = 1'b0;
    tx_data[i]  = ~w;
    chk($sformatf("%s.accept_busy", tag), 32'(busy[i]), 32'd1);
    chk($sformatf("%s.accept_cs", tag), 32'(cs[i]), 32'd0);
    chk($sformatf("%s.accept_mosi", tag), 32'(mosi[i]), 32'(w[DW-1]));
  endtask

  task automatic check_frame(input int i, input logic [DW-1:0] exp_rx, input logic [DW-1:0] exp_mosi,
                             input int dvb, input string tag);
    int d = div_of(i);
    chk($sformatf("%s.dv_count", tag), 32'(dv_cnt[i] - dvb), 32'd1);
    chk($sformatf("%s.rx_pulse", tag), 32'(rx_last[i]), 32'(exp_rx));
    chk($sformatf("%s.rx_hold", tag), 32'(rx_data[i]), 32'(exp_rx));
    chk($sformatf("%s.mosi_bits", tag), 32'(last_mosi[i]), 32'(exp_mosi));
    chk($sformatf("%s.cs_low_len", tag), 32'(last_lo_len[i]), 32'((2 * DW + 1) * d));
    chk($sformatf("%s.sclk_rises", tag), 32'(last_rise[i]), 32'(DW));
    chk($sformatf("%s.sclk_hi_min", tag), 32'(hi_min[i]), 32'(d));
    chk($sformatf("%s.sclk_hi_max", tag), 32'(hi_max[i]), 32'(d));
    chk($sformatf("%s.busy_len", tag), 32'(last_busy_len[i]), 32'((2 * DW + 1) * d + gap_of(i)));
    chk($sformatf("%s.sclk_vs_cs", tag), 32'(bad_sclk[i]), 32'd0);
    chk($sformatf("%s.dv_align", tag), 32'(bad_dv[i]), 32'd0);
  endtask

  task automatic run_frame(input int i, input logic [DW-1:0] w, input logic [DW-1:0] pat, input bit lp,
                           input logic [DW-1:0] exp_rx, input logic [DW-1:0] exp_mosi, input string tag);
    int dvb;
    loop_en[i]   = lp;
    slave_pat[i] = pat;
    clear_flags(i);
    @(negedge clk);
    #1;
    dvb = dv_cnt[i];
    start_frame(i, w, tag);
    wait_busy(i, 1'b0, tag);
    check_frame(i, exp_rx, exp_mosi, dvb, tag);
  endtask

  // tx_start held high across two frames; the second word is loaded after the first acceptance
  task automatic held_pair(input int i, input logic [DW-1:0] w1, input logic [DW-1:0] w2, input string tag);
    int dvb;
    loop_en[i] = 1'b1;
    clear_flags(i);
    @(negedge clk);
    #1;
    dvb         = dv_cnt[i];
    tx_data[i]  = w1;
    tx_start[i] = 1'b1;
    @(negedge clk);
    #1;
    tx_data[i] = w2;
    chk($sformatf("%s.accept1", tag), 32'(busy[i]), 32'd1);
    wait_busy(i, 1'b0, tag);
    wait_busy(i, 1'b1, tag);
    tx_start[i] = 1'b0;
    wait_busy(i, 1'b0, tag);
    chk($sformatf("%s.dv_count", tag), 32'(dv_cnt[i] - dvb), 32'd2);
    chk($sformatf("%s.rx_first", tag), 32'(rx_prev[i]), 32'(w1));
    chk($sformatf("%s.rx_second", tag), 32'(rx_last[i]), 32'(w2));
    chk($sformatf("%s.mosi_second", tag), 32'(last_mosi[i]), 32'(w2));
    chk($sformatf("%s.cs_gap_len", tag), 32'(last_gap[i]), 32'(gap_of(i) + 1));
    chk($sformatf("%s.cs_low_len", tag), 32'(last_lo_len[i]), 32'((2 * DW + 1) * div_of(i)));
    chk($sformatf("%s.dv_align", tag), 32'(bad_dv[i]), 32'd0);
  endtask

  typedef struct {
    int            dut;
    logic [DW-1:0] tx;
    logic [DW-1:0] pat;
    bit            lp;
    logic [DW-1:0] exp_rx;
    logic [DW-1:0] exp_mosi;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int dvb, fb, n;
    logic [DW-1:0] w, pat;
    bit lp;
    int i;

    vecs[0] = '{0, 8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5};
    vecs[1] = '{0, 8'hFF, 8'h3C, 1'b0, 8'h3C, 8'hFF};
    vecs[2] = '{0, 8'h00, 8'hFF, 1'b0, 8'hFF, 8'h00};
    vecs[3] = '{0, 8'h80, 8'h01, 1'b0, 8'h01, 8'h80};
    vecs[4] = '{0, 8'h01, 8'h81, 1'b1, 8'h01, 8'h01};
    vecs[5] = '{1, 8'hC3, 8'h00, 1'b1, 8'hC3, 8'hC3};
    vecs[6] = '{1, 8'h3C, 8'h96, 1'b0, 8'h96, 8'h3C};
    vecs[7] = '{1, 8'h7E, 8'h5A, 1'b0, 8'h5A, 8'h7E};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tx_start[k]  = 1'b0;
      tx_data[k]   = '0;
      loop_en[k]   = 1'b0;
      slave_pat[k] = '0;
      slave_bit[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset%0d.cs", k), 32'(cs[k]), 32'd1);
      chk($sformatf("reset%0d.sclk", k), 32'(sclk[k]), 32'd0);
      chk($sformatf("reset%0d.mosi", k), 32'(mosi[k]), 32'd0);
      chk($sformatf("reset%0d.busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("reset%0d.dv", k), 32'(dv[k]), 32'd0);
      chk($sformatf("reset%0d.rx", k), 32'(rx_data[k]), 32'd0);
    end
    mon_en = 1'b1;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++)
      run_frame(vecs[v].dut, vecs[v].tx, vecs[v].pat, vecs[v].lp, vecs[v].exp_rx, vecs[v].exp_mosi,
                $sformatf("vec%0d", v));

    for (int r = 0; r < 16; r++) begin
      i   = int'($urandom_range(0, 1));
      w   = DW'($urandom);
      pat = DW'($urandom);
      lp  = 1'($urandom);
      run_frame(i, w, pat, lp, lp ? w : pat, w, $sformatf("rnd%0d", r));
    end

    // Request during a frame (3rd sclk rise) must be dropped, not queued
    loop_en[0]   = 1'b0;
    slave_pat[0] = 8'h3C;
    clear_flags(0);
    @(negedge clk);
    #1;
    dvb = dv_cnt[0];
    fb  = frames[0];
    start_frame(0, 8'hFF, "ignore");
    n = 0;
    while (cur_rise[0] < 3 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ignore.reach_rise3", 32'(cur_rise[0] >= 3), 32'd1);
    tx_data[0]  = 8'h11;
    tx_start[0] = 1'b1;
    @(negedge clk);
    #1;
    tx_start[0] = 1'b0;
    wait_busy(0, 1'b0, "ignore");
    check_frame(0, 8'h3C, 8'hFF, dvb, "ignore");
    repeat (40) @(negedge clk);
    #1;
    chk("ignore.frames", 32'(frames[0] - fb), 32'd1);
    chk("ignore.cs_idle", 32'(cs[0]), 32'd1);
    chk("ignore.busy_idle", 32'(busy[0]), 32'd0);

    // Reset one cycle after the 5th sclk rise aborts the frame
    loop_en[0] = 1'b1;
    @(negedge clk);
    #1;
    dvb = dv_cnt[0];
    start_frame(0, 8'h3C, "abort");
    n = 0;
    while (cur_rise[0] < 5 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort.reach_rise5", 32'(cur_rise[0] >= 5), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort.cs", 32'(cs[0]), 32'd1);
    chk("abort.sclk", 32'(sclk[0]), 32'd0);
    chk("abort.busy", 32'(busy[0]), 32'd0);
    chk("abort.dv", 32'(dv[0]), 32'd0);
    chk("abort.rx", 32'(rx_data[0]), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    chk("abort.no_pulse", 32'(dv_cnt[0] - dvb), 32'd0);
    run_frame(0, 8'h5A, 8'h00, 1'b1, 8'h5A, 8'h5A, "after_abort");

    held_pair(0, 8'h01, 8'h80, "heldA");
    held_pair(1, 8'hA5, 8'h3C, "heldB");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
